nibble_serial_add_ctrl: RTL

//  Time-multiplexes one external 4-bit ripple-carry adder to perform a wide
//  (WIDTH*NIBBLES-bit) addition, one nibble per clock, LSB nibble first.

---
 rtl/nibble_serial_add_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide adder: time-multiplexes an external WIDTH-bit adder, one slice per clock, LSB first.
// Optional macro ACCUMULATE_EN: operand A is taken from the previous result (running-sum accumulator).
module nibble_serial_add_ctrl #(
    parameter int WIDTH   = 4,
    parameter int NIBBLES = 4,
    localparam int TOTAL  = WIDTH * NIBBLES
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TOTAL-1:0] op_a,
    input  logic [TOTAL-1:0] op_b,
    input  logic             cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TOTAL-1:0] result,
    output logic             cout_out
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TOTAL-1:0]   a_q, a_d;
    logic [TOTAL-1:0]   b_q, b_d;
    logic [TOTAL-1:0]   result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [TOTAL-1:0]   a_load;

`ifdef ACCUMULATE_EN
    logic [TOTAL-1:0]   unused_op_a;
    assign unused_op_a = op_a;
    assign a_load      = result_q;
`else
    assign a_load      = op_a;
`endif

    always_comb begin
        // NOTE: every _d gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a_load;
                    b_d        = op_b;
                    carry_d    = cin;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                result_d[int'(idx_q)*WIDTH +: WIDTH] = add_s;
                carry_d = add_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d      = add_cout;
                    out_valid_d = 1'b1;
                    idx_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Adder inputs are gated to zero outside RUN so the external adder stays quiet.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[int'(idx_q)*WIDTH +: WIDTH];
            add_b   = b_q[int'(idx_q)*WIDTH +: WIDTH];
            add_cin = carry_q;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout_out  = cout_q;

endmodule
